// File: rtl/task_dispatcher_if.sv
// AXI-lite style control port used by task_dispatcher (single-beat, no strobes).
interface if_axi_light #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/task_dispatcher.sv
// Task FIFO plus round-robin dispatch into per-node mailboxes, polled/released over AXI-lite.
// Optional tasks_done counter at node index 31 when TASK_DISPATCHER_STATS_EN is defined.
module task_dispatcher #(
  parameter int NODES          = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          task_valid,
  input  logic [AXI_DATA_WIDTH-1:0]     task_addr,
  output logic                          task_ready,
  if_axi_light.slave                    s_axi,
  output logic [NODES-1:0]              node_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_zero
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [AXI_DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0]             r_wr_ptr, r_rd_ptr;
  logic [PW:0]               r_count;
  logic                      r_task_ready;
  logic                      r_err_zero;
  logic [AXI_DATA_WIDTH-1:0] r_mbox [NODES];
  logic [4:0]                r_rr_ptr;

  logic                      w_push, w_enq, w_disp, w_found;
  logic [4:0]                w_disp_idx;
  logic [AXI_DATA_WIDTH-1:0] w_head;
  logic [PW:0]               w_count_next;
  int                        w_n;
  logic [AXI_DATA_WIDTH-1:0] w_stats_val;

`ifdef TASK_DISPATCHER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  assign task_ready = r_task_ready;
  assign fifo_count = r_count;
  assign err_zero   = r_err_zero;

  generate
    for (genvar gi = 0; gi < NODES; gi++) begin : g_busy
      assign node_busy[gi] = |r_mbox[gi];
    end
  endgenerate

  // ---------------- FIFO ----------------
  assign w_push       = task_valid && r_task_ready;
  assign w_enq        = w_push && (|task_addr);
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_count_next = r_count + {{PW{1'b0}}, w_enq} - {{PW{1'b0}}, w_disp};

  always_ff @(posedge clk) begin
    if (w_enq) r_fifo[r_wr_ptr] <= task_addr;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_task_ready <= 1'b1;
      r_err_zero   <= 1'b0;
    end else begin
      if (w_enq)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_disp) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count      <= w_count_next;
      r_task_ready <= (w_count_next != (PW+1)'(FIFO_DEPTH));
      if (w_push && !(|task_addr)) r_err_zero <= 1'b1;
    end
  end

  // First idle node at or after rr_ptr, wrapping; mailbox state is pre-write.
  always_comb begin
    w_found    = 1'b0;
    w_disp_idx = '0;
    w_n        = 0;
    for (int k = 0; k < NODES; k++) begin
      w_n = int'(r_rr_ptr) + k;
      if (w_n >= NODES) w_n = w_n - NODES;
      if (!w_found && r_mbox[w_n] == '0) begin
        w_found    = 1'b1;
        w_disp_idx = 5'(w_n);
      end
    end
  end

  assign w_disp = w_found && (r_count != '0);

  // ---------------- address decode ----------------
  logic [4:0] w_ar_idx, w_aw_idx;
  logic       w_ar_err, w_aw_err;

  assign w_ar_idx = s_axi.araddr[6:2];
  assign w_aw_idx = s_axi.awaddr[6:2];
  assign w_ar_err = !(s_axi.araddr[AXI_ADDR_WIDTH-1] && s_axi.araddr[7]) ||
                    ((int'(w_ar_idx) >= NODES) && !(STATS && w_ar_idx == 5'd31));
  assign w_aw_err = !(s_axi.awaddr[AXI_ADDR_WIDTH-1] && s_axi.awaddr[7]) ||
                    ((int'(w_aw_idx) >= NODES) && !(STATS && w_aw_idx == 5'd31));

  logic [AXI_DATA_WIDTH-1:0] w_ar_data;
  always_comb begin
    w_ar_data = '0;
    for (int n = 0; n < NODES; n++) begin
      if (w_ar_idx == 5'(n)) w_ar_data = r_mbox[n];
    end
    if (STATS && w_ar_idx == 5'd31) w_ar_data = w_stats_val;
  end

  // ---------------- read FSM ----------------
  typedef enum logic {R_IDLE, R_RESP} rstate_t;
  rstate_t                   r_rstate;
  logic                      r_arready, r_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp;

  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  always_ff @(posedge clk) begin
    if (res) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: if (s_axi.arvalid) begin
          r_rstate  <= R_RESP;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b1;
          r_rdata   <= w_ar_err ? '0 : w_ar_data;
          r_rresp   <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
        end
        R_RESP: if (s_axi.rready) begin
          r_rstate  <= R_IDLE;
          r_arready <= 1'b1;
          r_rvalid  <= 1'b0;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- write FSM ----------------
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  wstate_t    r_wstate;
  logic       r_awready, r_wready, r_bvalid;
  logic [1:0] r_bresp;
  logic       r_aw_done, r_w_done, r_aw_err;
  logic [4:0] r_aw_idx;

  logic       w_aw_fire, w_w_fire, w_wr_do, w_wr_err, w_wr_nz, w_rel;
  logic [4:0] w_wr_idx;

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;

  assign w_aw_fire = r_awready && s_axi.awvalid;
  assign w_w_fire  = r_wready && s_axi.wvalid;
  assign w_wr_do   = (r_wstate == W_IDLE) && (r_aw_done || w_aw_fire) && (r_w_done || w_w_fire);
  assign w_wr_idx  = r_aw_done ? r_aw_idx : w_aw_idx;
  assign w_wr_err  = r_aw_done ? r_aw_err : w_aw_err;

  always_comb begin
    w_wr_nz = 1'b0;
    for (int n = 0; n < NODES; n++) begin
      if (w_wr_idx == 5'(n)) w_wr_nz = |r_mbox[n];
    end
  end

  // Writes to an idle mailbox are spurious and leave all state untouched.
  assign w_rel = w_wr_do && !w_wr_err && (int'(w_wr_idx) < NODES) && w_wr_nz;

  always_ff @(posedge clk) begin
    if (res) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_aw_err  <= 1'b0;
      r_aw_idx  <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_fire) begin
            r_aw_done <= 1'b1;
            r_aw_idx  <= w_aw_idx;
            r_aw_err  <= w_aw_err;
            r_awready <= 1'b0;
          end
          if (w_w_fire) begin
            r_w_done <= 1'b1;
            r_wready <= 1'b0;
          end
          if (w_wr_do) begin
            r_wstate  <= W_RESP;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
          end
        end
        W_RESP: if (s_axi.bready) begin
          r_wstate  <= W_IDLE;
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Dispatch only targets idle mailboxes and release only busy ones, so they never collide.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int n = 0; n < NODES; n++) r_mbox[n] <= '0;
      r_rr_ptr <= '0;
    end else begin
      for (int n = 0; n < NODES; n++) begin
        if (w_disp && w_disp_idx == 5'(n))     r_mbox[n] <= w_head;
        else if (w_rel && w_wr_idx == 5'(n))   r_mbox[n] <= '0;
      end
      if (w_disp) r_rr_ptr <= (int'(w_disp_idx) == NODES - 1) ? 5'd0 : w_disp_idx + 5'd1;
    end
  end

`ifdef TASK_DISPATCHER_STATS_EN
  logic [31:0] r_tasks_done;
  logic        w_stat_clr;

  assign w_stat_clr  = w_wr_do && !w_wr_err && (w_wr_idx == 5'd31);
  assign w_stats_val = AXI_DATA_WIDTH'(r_tasks_done);

  always_ff @(posedge clk) begin
    if (res) begin
      r_tasks_done <= '0;
    end else begin
      if (w_stat_clr)  r_tasks_done <= '0;
      else if (w_rel)  r_tasks_done <= r_tasks_done + 32'd1;
      if (w_disp) $display("dispatch node %0d addr 0x%0h", w_disp_idx, w_head);
      if (w_rel)  $display("release  node %0d", w_wr_idx);
    end
  end
`else
  assign w_stats_val = '0;
`endif

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed, table-driven and randomized checks of task_dispatcher (NODES=4, FIFO_DEPTH=8).
module tb_task_dispatcher;
  localparam int NN = 4;
  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        task_valid = 1'b0;
  logic [31:0] task_addr = '0;
  logic        task_ready;
  logic [NN-1:0] node_busy;
  logic [3:0]  fifo_count;
  logic        err_zero;

  int n_checks = 0;
  int n_fail   = 0;

  if_axi_light #(.ADDR_W(32), .DATA_W(32)) ax ();

  task_dispatcher #(.NODES(NN), .FIFO_DEPTH(FD), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .clk        (clk),
    .res        (res),
    .task_valid (task_valid),
    .task_addr  (task_addr),
    .task_ready (task_ready),
    .s_axi      (ax),
    .node_busy  (node_busy),
    .fifo_count (fifo_count),
    .err_zero   (err_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout required handshake", name);
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    tick();
    res = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cnt;
    ax.araddr = addr; ax.arvalid = 1'b1; ax.rready = 1'b1;
    cnt = 0;
    while (!ax.arready && cnt < 20) begin tick(); cnt++; end
    if (cnt == 20) timeout("arready");
    tick();
    ax.arvalid = 1'b0;
    cnt = 0;
    while (!ax.rvalid && cnt < 20) begin tick(); cnt++; end
    if (cnt == 20) timeout("rvalid");
    data = ax.rdata;
    resp = ax.rresp;
    tick();
    ax.rready = 1'b0;
    $display("read  addr=0x%08h data=0x%0h resp=%0d", addr, data, resp);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int cnt;
    ax.awaddr = addr; ax.wdata = data; ax.awvalid = 1'b1; ax.wvalid = 1'b1; ax.bready = 1'b1;
    cnt = 0;
    while (!(ax.awready && ax.wready) && cnt < 20) begin tick(); cnt++; end
    if (cnt == 20) timeout("awready");
    tick();
    ax.awvalid = 1'b0; ax.wvalid = 1'b0;
    cnt = 0;
    while (!ax.bvalid && cnt < 20) begin tick(); cnt++; end
    if (cnt == 20) timeout("bvalid");
    resp = ax.bresp;
    tick();
    ax.bready = 1'b0;
    $display("write addr=0x%08h data=0x%0h resp=%0d", addr, data, resp);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[14];

  // Behavioural model for the randomized phase
  logic [31:0] m_mbox [NN];
  logic [31:0] m_q [$];
  int          m_rr;
  bit          m_err, m_rph, m_wph;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [31:0] tasks [6];

    ax.awaddr = '0; ax.awvalid = 1'b0; ax.wdata = '0; ax.wvalid = 1'b0; ax.bready = 1'b0;
    ax.araddr = '0; ax.arvalid = 1'b0; ax.rready = 1'b0;

    do_reset();

    // reset state
    check("rst_task_ready", 32'(task_ready), 32'd1);
    check("rst_node_busy",  32'(node_busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_err_zero",   32'(err_zero), 32'd0);
    check("rst_arready",    32'(ax.arready), 32'd1);
    check("rst_awready",    32'(ax.awready), 32'd1);
    check("rst_wready",     32'(ax.wready), 32'd1);
    check("rst_rvalid",     32'(ax.rvalid), 32'd0);
    check("rst_bvalid",     32'(ax.bvalid), 32'd0);
    check("rst_rdata",      ax.rdata, 32'd0);
    check("rst_resps",      32'({ax.rresp, ax.bresp}), 32'd0);

    // two consecutive pushes, dispatched on consecutive cycles
    task_valid = 1'b1; task_addr = 32'h1000;
    tick();
    check("p1_count", 32'(fifo_count), 32'd1);
    check("p1_busy",  32'(node_busy), 32'd0);
    task_addr = 32'h2000;
    tick();
    task_valid = 1'b0;
    check("p2_count", 32'(fifo_count), 32'd1);
    check("p2_busy",  32'(node_busy), 32'b0001);
    tick();
    check("p3_count", 32'(fifo_count), 32'd0);
    check("p3_busy",  32'(node_busy), 32'b0011);

    // decode / release table (node0=0x1000, node1=0x2000)
    vecs[0]  = '{1'b0, 32'h8000_0080, 32'h0, 32'h1000, 2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0084, 32'h0, 32'h2000, 2'b00};
    vecs[2]  = '{1'b0, 32'h8000_0087, 32'h0, 32'h2000, 2'b00};
    vecs[3]  = '{1'b0, 32'h8000_0088, 32'h0, 32'h0,    2'b00};
    vecs[4]  = '{1'b0, 32'h8000_0094, 32'h0, 32'h0,    2'b10};
    vecs[5]  = '{1'b0, 32'h0000_0084, 32'h0, 32'h0,    2'b10};
    vecs[6]  = '{1'b0, 32'h8000_0004, 32'h0, 32'h0,    2'b10};
`ifdef TASK_DISPATCHER_STATS_EN
    vecs[7]  = '{1'b0, 32'h8000_00FC, 32'h0, 32'h0,    2'b00};
`else
    vecs[7]  = '{1'b0, 32'h8000_00FC, 32'h0, 32'h0,    2'b10};
`endif
    vecs[8]  = '{1'b1, 32'h8000_0084, 32'h0, 32'h0,    2'b00};
    vecs[9]  = '{1'b0, 32'h8000_0084, 32'h0, 32'h0,    2'b00};
    vecs[10] = '{1'b1, 32'h8000_0084, 32'h5, 32'h0,    2'b00};
    vecs[11] = '{1'b1, 32'h8000_0094, 32'h0, 32'h0,    2'b10};
    vecs[12] = '{1'b1, 32'h0000_0080, 32'h0, 32'h0,    2'b10};
    vecs[13] = '{1'b0, 32'h8000_0080, 32'h0, 32'h1000, 2'b00};

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].wdata, rs);
        check($sformatf("vec%0d_bresp", i), 32'(rs), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, rd, rs);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), 32'(rs), 32'(vecs[i].exp_resp));
      end
    end
    check("vec_busy", 32'(node_busy), 32'b0001);

    // six tasks into four idle nodes, then release node 2
    do_reset();
    tasks = '{32'h2000, 32'h3000, 32'h4000, 32'h5000, 32'h6000, 32'h7000};
    for (int i = 0; i < 6; i++) begin
      task_valid = 1'b1; task_addr = tasks[i];
      tick();
    end
    task_valid = 1'b0;
    tick();
    tick();
    check("six_count", 32'(fifo_count), 32'd2);
    check("six_busy",  32'(node_busy), 32'hF);
    axi_read(32'h8000_0084, rd, rs);
    check("six_n1_data", rd, 32'h3000);
    check("six_n1_resp", 32'(rs), 32'd0);

    ax.awaddr = 32'h8000_0088; ax.wdata = 32'h0; ax.awvalid = 1'b1; ax.wvalid = 1'b1; ax.bready = 1'b0;
    tick();
    ax.awvalid = 1'b0; ax.wvalid = 1'b0;
    check("rel_busy_e0",  32'(node_busy), 32'b1011);
    check("rel_bvalid",   32'(ax.bvalid), 32'd1);
    check("rel_count_e0", 32'(fifo_count), 32'd2);
    tick();
    check("rel_busy_e1",  32'(node_busy), 32'hF);
    check("rel_count_e1", 32'(fifo_count), 32'd1);
    ax.bready = 1'b1;
    tick();
    ax.bready = 1'b0;
    check("rel_bvalid_done", 32'(ax.bvalid), 32'd0);
    axi_read(32'h8000_0088, rd, rs);
    check("rel_n2_data", rd, 32'h6000);

    // zero address is dropped and latches err_zero
    task_valid = 1'b1; task_addr = 32'h0;
    tick();
    task_valid = 1'b0;
    check("zero_count", 32'(fifo_count), 32'd1);
    check("zero_err",   32'(err_zero), 32'd1);

    // fill the FIFO with all nodes busy
    for (int i = 0; i < 7; i++) begin
      task_valid = 1'b1; task_addr = 32'h9000 + 32'(i) * 32'h100;
      tick();
    end
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_ready", 32'(task_ready), 32'd0);
    task_addr = 32'hDEA0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold_count", 32'(fifo_count), 32'd8);
    end
    ax.awaddr = 32'h8000_0080; ax.wdata = 32'h0; ax.awvalid = 1'b1; ax.wvalid = 1'b1; ax.bready = 1'b1;
    tick();
    ax.awvalid = 1'b0; ax.wvalid = 1'b0;
    check("full_e0_ready", 32'(task_ready), 32'd0);
    check("full_e0_count", 32'(fifo_count), 32'd8);
    tick();
    ax.bready = 1'b0;
    check("full_e1_ready", 32'(task_ready), 32'd1);
    check("full_e1_count", 32'(fifo_count), 32'd7);
    tick();
    task_valid = 1'b0;
    check("full_e2_ready", 32'(task_ready), 32'd0);
    check("full_e2_count", 32'(fifo_count), 32'd8);
    check("full_err_sticky", 32'(err_zero), 32'd1);

    // reset while a read response is pending
    ax.araddr = 32'h8000_0080; ax.arvalid = 1'b1; ax.rready = 1'b0;
    tick();
    ax.arvalid = 1'b0;
    check("mid_rvalid_pre", 32'(ax.rvalid), 32'd1);
    res = 1'b1;
    tick();
    res = 1'b0;
    check("mid_rvalid", 32'(ax.rvalid), 32'd0);
    check("mid_arready", 32'(ax.arready), 32'd1);
    check("mid_count",  32'(fifo_count), 32'd0);
    check("mid_ready",  32'(task_ready), 32'd1);
    check("mid_err",    32'(err_zero), 32'd0);
    check("mid_busy",   32'(node_busy), 32'd0);
    tick();

    // randomized traffic against the queue/array model
    for (int n = 0; n < NN; n++) m_mbox[n] = '0;
    m_q.delete();
    m_rr = 0; m_err = 0; m_rph = 0; m_wph = 0;
    m_rdata = '0; m_rresp = '0; m_bresp = '0;
    ax.rready = 1'b1; ax.bready = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int busy, d_node, rel_node, idx;
      bit enq;
      logic [31:0] head;

      busy = 0;
      for (int n = 0; n < NN; n++) if (m_mbox[n] != 0) busy |= (1 << n);
      check("rnd_ready", 32'(task_ready), 32'(m_q.size() != FD));
      check("rnd_count", 32'(fifo_count), 32'(m_q.size()));
      check("rnd_busy",  32'(node_busy), 32'(busy));
      check("rnd_err",   32'(err_zero), 32'(m_err));
      check("rnd_rvalid", 32'(ax.rvalid), 32'(m_rph));
      check("rnd_bvalid", 32'(ax.bvalid), 32'(m_wph));
      if (m_rph) begin
        check("rnd_rdata", ax.rdata, m_rdata);
        check("rnd_rresp", 32'(ax.rresp), 32'(m_rresp));
      end
      if (m_wph) check("rnd_bresp", 32'(ax.bresp), 32'(m_bresp));

      task_valid = ($urandom_range(0, 99) < 60);
      task_addr  = ($urandom_range(0, 9) == 0) ? 32'h0 : (($urandom & 32'h00FF_FFF0) | 32'h10);
      if (!m_wph && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 4);
        ax.awaddr = 32'h8000_0080 | (32'(idx) << 2);
        ax.wdata = $urandom; ax.awvalid = 1'b1; ax.wvalid = 1'b1;
      end else begin
        ax.awvalid = 1'b0; ax.wvalid = 1'b0;
      end
      if (!m_rph && $urandom_range(0, 1) == 0) begin
        idx = $urandom_range(0, 5);
        ax.araddr = 32'h8000_0080 | (32'(idx) << 2);
        ax.arvalid = 1'b1;
      end else begin
        ax.arvalid = 1'b0;
      end

      // model the coming edge from the current (pre-edge) state
      d_node = -1;
      if (m_q.size() > 0) begin
        for (int k = 0; k < NN; k++) begin
          int n;
          n = (m_rr + k) % NN;
          if (d_node < 0 && m_mbox[n] == 0) d_node = n;
        end
      end
      if (m_rph) m_rph = 0;
      else if (ax.arvalid) begin
        idx = int'(ax.araddr[6:2]);
        m_rdata = (idx < NN) ? m_mbox[idx] : 32'h0;
        m_rresp = (idx < NN) ? 2'b00 : 2'b10;
        m_rph = 1;
      end
      rel_node = -1;
      if (m_wph) m_wph = 0;
      else if (ax.awvalid) begin
        idx = int'(ax.awaddr[6:2]);
        m_bresp = (idx < NN) ? 2'b00 : 2'b10;
        if (idx < NN && m_mbox[idx] != 0) rel_node = idx;
        m_wph = 1;
      end
      enq = 0;
      if (task_valid && m_q.size() != FD) begin
        if (task_addr == 0) m_err = 1;
        else enq = 1;
      end
      if (d_node >= 0) begin
        head = m_q.pop_front();
        m_mbox[d_node] = head;
        m_rr = (d_node + 1) % NN;
      end
      if (rel_node >= 0) m_mbox[rel_node] = '0;
      if (enq) m_q.push_back(task_addr);
      tick();
    end
    task_valid = 1'b0; ax.awvalid = 1'b0; ax.wvalid = 1'b0; ax.arvalid = 1'b0;
    ax.rready = 1'b0; ax.bready = 1'b0;
    tick();
    tick();

`ifdef TASK_DISPATCHER_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      task_valid = 1'b1; task_addr = 32'hA000 + 32'(i) * 32'h10;
      tick();
    end
    task_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) axi_write(32'h8000_0080 | (32'(i) << 2), 32'h0, rs);
    axi_read(32'h8000_00FC, rd, rs);
    check("stats_three", rd, 32'd3);
    check("stats_resp", 32'(rs), 32'd0);
    axi_write(32'h8000_0080, 32'h0, rs);
    axi_read(32'h8000_00FC, rd, rs);
    check("stats_spurious", rd, 32'd3);
    axi_write(32'h8000_00FC, 32'h1, rs);
    axi_read(32'h8000_00FC, rd, rs);
    check("stats_clear", rd, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
